// File: rtl/pipeline_run_controller.sv
// Debug-flow sequencer for the MIPS pipeline: run/step control, HALT drain,
// and a byte-serial state dump (cycle count, PC, registers, data memory).
module pipeline_run_controller #(
    parameter int         NB_DATA      = 32,
    parameter int         NB_REG       = 5,
    parameter int         NB_ADDR      = 7,
    parameter int         N_MEM_WORDS  = 32,
    parameter int         DRAIN_CYCLES = 4,
    parameter logic [5:0] HALT_OPCODE  = 6'b111111
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               program_loaded_i,
    input  logic [7:0]         cmd_i,
    input  logic               cmd_valid_i,
    input  logic [NB_DATA-1:0] instruction_fetch_i,
    input  logic [6:0]         pc_i,
    input  logic [NB_DATA-1:0] data_registers_debug_i,
    input  logic [NB_DATA-1:0] data_mem_debug_i,
    input  logic               tx_done_i,
    output logic               en_pipeline_o,
    output logic               pc_enable_o,
    output logic               select_debug_o,
    output logic [NB_REG-1:0]  addr_reg_debug_o,
    output logic [NB_ADDR-1:0] addr_mem_debug_o,
    output logic [7:0]         tx_data_o,
    output logic               tx_start_o,
    output logic               busy_o,
    output logic               halted_o,
    output logic [31:0]        cycle_count_o
);

    localparam int N_WORDS  = 34 + N_MEM_WORDS;
    localparam int NB_IDX   = $clog2(N_WORDS);
    localparam int NB_DRAIN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [7:0]          CMD_RUN    = 8'h63;
    localparam logic [7:0]          CMD_STEP   = 8'h73;
    localparam logic [NB_IDX-1:0]   IDX_PC     = NB_IDX'(1);
    localparam logic [NB_IDX-1:0]   IDX_REG0   = NB_IDX'(2);
    localparam logic [NB_IDX-1:0]   IDX_MEM0   = NB_IDX'(34);
    localparam logic [NB_IDX-1:0]   IDX_LAST   = NB_IDX'(N_WORDS - 1);
    localparam logic [NB_DRAIN-1:0] DRAIN_LAST = NB_DRAIN'(DRAIN_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE,
        RUN,
        STEP,
        DRAIN,
        DUMP_ADDR,
        DUMP_LATCH,
        DUMP_SEND,
        DUMP_WAIT,
        HALTED
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          cycle_count_q;
    logic [31:0]          shift_q;
    logic [31:0]          word_sel;
    logic [NB_IDX-1:0]    word_idx_q, word_idx_d;
    logic [1:0]           byte_cnt_q;
    logic [NB_DRAIN-1:0]  drain_cnt_q;
    logic                 halt_flag_q;
    logic [NB_REG-1:0]    addr_reg_q;
    logic [NB_ADDR-1:0]   addr_mem_q;
    logic                 halt_at_fetch;
    logic                 cmd_ok;
    logic                 byte_last;
    logic                 word_last;
    logic                 unused_fetch_bits;

    assign halt_at_fetch     = (instruction_fetch_i[NB_DATA-1 -: 6] == HALT_OPCODE);
    assign unused_fetch_bits = &{1'b0, instruction_fetch_i[NB_DATA-7:0]};
    assign cmd_ok            = cmd_valid_i && program_loaded_i;
    assign byte_last         = (byte_cnt_q == 2'd3);
    assign word_last         = (word_idx_q == IDX_LAST);

    // First word of a dump starts at index 0; later words follow the last one sent.
    assign word_idx_d = (state_q == DUMP_WAIT) ? word_idx_q + NB_IDX'(1) : '0;

    always_comb begin
        word_sel = 32'(data_mem_debug_i);
        if (word_idx_q == '0)
            word_sel = cycle_count_q;
        else if (word_idx_q == IDX_PC)
            word_sel = {25'b0, pc_i};
        else if (word_idx_q < IDX_MEM0)
            word_sel = 32'(data_registers_debug_i);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        en_pipeline_o  = 1'b0;
        pc_enable_o    = 1'b0;
        select_debug_o = 1'b0;
        tx_start_o     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_ok && cmd_i == CMD_RUN)
                    state_d = RUN;
                else if (cmd_ok && cmd_i == CMD_STEP)
                    state_d = STEP;
            end
            RUN: begin
                en_pipeline_o = 1'b1;
                if (halt_at_fetch)
                    state_d = DRAIN;
                else
                    pc_enable_o = 1'b1;
            end
            STEP: begin
                en_pipeline_o = 1'b1;
                if (halt_at_fetch) begin
                    state_d = DRAIN;
                end else begin
                    pc_enable_o = 1'b1;
                    state_d     = DUMP_ADDR;
                end
            end
            DRAIN: begin
                en_pipeline_o = 1'b1;
                if (drain_cnt_q == DRAIN_LAST)
                    state_d = DUMP_ADDR;
            end
            DUMP_ADDR: begin
                select_debug_o = 1'b1;
                state_d        = DUMP_LATCH;
            end
            DUMP_LATCH: begin
                select_debug_o = 1'b1;
                state_d        = DUMP_SEND;
            end
            DUMP_SEND: begin
                select_debug_o = 1'b1;
                tx_start_o     = 1'b1;
                state_d        = DUMP_WAIT;
            end
            DUMP_WAIT: begin
                // tx_done_i is only looked at here, so a pulse coincident with
                // tx_start_o can never complete a byte.
                select_debug_o = 1'b1;
                if (tx_done_i) begin
                    if (!byte_last)
                        state_d = DUMP_SEND;
                    else if (!word_last)
                        state_d = DUMP_ADDR;
                    else
                        state_d = halt_flag_q ? HALTED : IDLE;
                end
            end
            HALTED: state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cycle_count_q <= '0;
            shift_q       <= '0;
            word_idx_q    <= '0;
            byte_cnt_q    <= '0;
            drain_cnt_q   <= '0;
            halt_flag_q   <= 1'b0;
            addr_reg_q    <= '0;
            addr_mem_q    <= '0;
        end else begin
            if (en_pipeline_o)
                cycle_count_q <= cycle_count_q + 32'd1;
            drain_cnt_q <= (state_q == DRAIN) ? drain_cnt_q + NB_DRAIN'(1) : '0;
            if (state_d == DRAIN)
                halt_flag_q <= 1'b1;
            // Addresses are set on entry to DUMP_ADDR and held through DUMP_LATCH,
            // giving the read ports a full settle cycle before capture.
            if (state_d == DUMP_ADDR) begin
                word_idx_q <= word_idx_d;
                if (word_idx_d >= IDX_REG0 && word_idx_d < IDX_MEM0)
                    addr_reg_q <= NB_REG'(word_idx_d - IDX_REG0);
                if (word_idx_d >= IDX_MEM0)
                    addr_mem_q <= NB_ADDR'(word_idx_d - IDX_MEM0);
            end
            if (state_q == DUMP_LATCH) begin
                shift_q    <= word_sel;
                byte_cnt_q <= '0;
            end
            if (state_q == DUMP_WAIT && tx_done_i) begin
                shift_q    <= {shift_q[23:0], 8'h00};
                byte_cnt_q <= byte_cnt_q + 2'd1;
            end
        end
    end

    assign tx_data_o        = shift_q[31:24];
    assign addr_reg_debug_o = addr_reg_q;
    assign addr_mem_debug_o = addr_mem_q;
    assign cycle_count_o    = cycle_count_q;
    assign busy_o           = (state_q != IDLE) && (state_q != HALTED);
    assign halted_o         = (state_q == HALTED);

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Directed bench for pipeline_run_controller: expected dump bytes are queued
// when a command is issued and compared as each tx_start_o byte appears.
module tb_pipeline_run_controller;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0020;
    localparam logic [31:0] HALT_INSTR = 32'hFC00_0000;

    logic        clock = 1'b0;
    logic        reset_i = 1'b1;
    logic        program_loaded_i = 1'b0;
    logic [7:0]  cmd_i = 8'h00;
    logic        cmd_valid_i = 1'b0;
    logic [31:0] instruction_fetch_i;
    logic [6:0]  pc_i;
    logic [31:0] data_registers_debug_i;
    logic [31:0] data_mem_debug_i;
    logic        tx_done_i = 1'b0;
    logic        en_pipeline_o, pc_enable_o, select_debug_o;
    logic [4:0]  addr_reg_debug_o;
    logic [6:0]  addr_mem_debug_o;
    logic [7:0]  tx_data_o;
    logic        tx_start_o, busy_o, halted_o;
    logic [31:0] cycle_count_o;

    int          checks = 0;
    int          failures = 0;
    int          rx_cnt = 0;
    int          tx_delay = 2;
    int          en_cnt = 0;
    logic        halt_arm = 1'b0;
    logic [6:0]  pc_model = '0;
    logic [7:0]  sb_q[$];
    logic        uart_pend = 1'b0;
    int          uart_cnt = 0;
    logic [7:0]  uart_held = '0;

    pipeline_run_controller dut (
        .clock_i(clock), .reset_i(reset_i), .program_loaded_i(program_loaded_i),
        .cmd_i(cmd_i), .cmd_valid_i(cmd_valid_i), .instruction_fetch_i(instruction_fetch_i),
        .pc_i(pc_i), .data_registers_debug_i(data_registers_debug_i),
        .data_mem_debug_i(data_mem_debug_i), .tx_done_i(tx_done_i),
        .en_pipeline_o(en_pipeline_o), .pc_enable_o(pc_enable_o),
        .select_debug_o(select_debug_o), .addr_reg_debug_o(addr_reg_debug_o),
        .addr_mem_debug_o(addr_mem_debug_o), .tx_data_o(tx_data_o),
        .tx_start_o(tx_start_o), .busy_o(busy_o), .halted_o(halted_o),
        .cycle_count_o(cycle_count_o)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] reg_val(input int a);
        return 32'hA000_0000 ^ (32'(a) * 32'h0103_0507);
    endfunction

    function automatic logic [31:0] mem_val(input int a);
        return 32'h5000_0001 ^ (32'(a) * 32'h0709_0B0D);
    endfunction

    // Datapath stand-ins: PC and enabled-cycle counter, register file, data memory.
    always @(posedge clock) begin
        if (reset_i) begin
            pc_model <= '0;
            en_cnt   <= 0;
        end else begin
            if (pc_enable_o) pc_model <= pc_model + 7'd1;
            if (en_pipeline_o) en_cnt <= en_cnt + 1;
        end
    end

    assign pc_i = pc_model;
    assign instruction_fetch_i = (halt_arm && en_cnt == 9) ? HALT_INSTR : NOP_INSTR;
    assign data_registers_debug_i = select_debug_o ? reg_val(int'(addr_reg_debug_o)) : 32'h0;
    assign data_mem_debug_i = select_debug_o ? mem_val(int'(addr_mem_debug_o)) : 32'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // UART responder plus scoreboard consumer.
    always @(negedge clock) begin
        if (reset_i) begin
            uart_pend = 1'b0;
            tx_done_i = 1'b0;
        end else begin
            tx_done_i = 1'b0;
            if (uart_pend) begin
                chk("tx_data_stable", 64'(tx_data_o), 64'(uart_held));
                if (uart_cnt == 0) begin
                    tx_done_i = 1'b1;
                    uart_pend = 1'b0;
                end else begin
                    uart_cnt--;
                end
            end
            if (tx_start_o) begin
                chk("tx_start_overlap", 64'(uart_pend), 64'(0));
                uart_pend = 1'b1;
                uart_cnt  = tx_delay;
                uart_held = tx_data_o;
                rx_cnt++;
                chk("tx_expected_avail", 64'(sb_q.size() != 0), 64'(1));
                if (sb_q.size() != 0)
                    chk("tx_byte", 64'(tx_data_o), 64'(sb_q.pop_front()));
            end
        end
    end

    task automatic push_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) sb_q.push_back(w[b*8 +: 8]);
    endtask

    task automatic push_dump(input logic [31:0] cc, input logic [6:0] pc);
        push_word(cc);
        push_word({25'b0, pc});
        for (int r = 0; r < 32; r++) push_word(reg_val(r));
        for (int m = 0; m < 32; m++) push_word(mem_val(m));
    endtask

    task automatic send_cmd(input logic [7:0] b);
        @(negedge clock);
        cmd_i = b;
        cmd_valid_i = 1'b1;
        @(negedge clock);
        cmd_valid_i = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_en"}, 64'(en_pipeline_o), 64'(0));
        chk({tag, "_pc_en"}, 64'(pc_enable_o), 64'(0));
        chk({tag, "_sel"}, 64'(select_debug_o), 64'(0));
        chk({tag, "_tx_start"}, 64'(tx_start_o), 64'(0));
        chk({tag, "_busy"}, 64'(busy_o), 64'(0));
        chk({tag, "_halted"}, 64'(halted_o), 64'(0));
        chk({tag, "_addr_reg"}, 64'(addr_reg_debug_o), 64'(0));
        chk({tag, "_addr_mem"}, 64'(addr_mem_debug_o), 64'(0));
        chk({tag, "_tx_data"}, 64'(tx_data_o), 64'(0));
        chk({tag, "_cycles"}, 64'(cycle_count_o), 64'(0));
    endtask

    task automatic wait_dump(input int budget, input string tag);
        int n = 0;
        while (busy_o && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_done"}, 64'(busy_o), 64'(0));
        chk({tag, "_queue_empty"}, 64'(sb_q.size()), 64'(0));
    endtask

    initial begin
        int base;
        int n;
        repeat (3) @(negedge clock);
        check_reset("reset");
        reset_i = 1'b0;

        // Commands before the program is loaded are dropped.
        send_cmd(8'h63);
        send_cmd(8'h73);
        repeat (5) @(negedge clock);
        check_reset("unloaded");
        chk("unloaded_en_cycles", 64'(en_cnt), 64'(0));
        chk("unloaded_tx", 64'(rx_cnt), 64'(0));

        program_loaded_i = 1'b1;
        send_cmd(8'h41);
        chk("unknown_en", 64'(en_pipeline_o), 64'(0));
        chk("unknown_busy", 64'(busy_o), 64'(0));
        repeat (10) @(negedge clock);
        chk("unknown_en_cycles", 64'(en_cnt), 64'(0));
        chk("unknown_tx", 64'(rx_cnt), 64'(0));

        // Single step with a plain instruction at fetch.
        base = rx_cnt;
        push_dump(32'd1, 7'd1);
        send_cmd(8'h73);
        chk("step_en", 64'(en_pipeline_o), 64'(1));
        chk("step_pc_en", 64'(pc_enable_o), 64'(1));
        chk("step_busy", 64'(busy_o), 64'(1));
        @(negedge clock);
        chk("step_one_cycle", 64'(en_pipeline_o), 64'(0));
        chk("step_select", 64'(select_debug_o), 64'(1));
        wait_dump(5000, "step");
        chk("step_bytes", 64'(rx_cnt - base), 64'(264));
        chk("step_halted", 64'(halted_o), 64'(0));
        chk("step_en_cycles", 64'(en_cnt), 64'(1));
        chk("step_cycles", 64'(cycle_count_o), 64'(1));

        // Reset in the middle of the register section of a dump.
        base = rx_cnt;
        push_dump(32'd2, 7'd2);
        send_cmd(8'h73);
        n = 0;
        while (rx_cnt - base < 40 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        chk("midreset_reached", 64'(rx_cnt - base >= 40), 64'(1));
        reset_i = 1'b1;
        @(negedge clock);
        check_reset("midreset");
        reset_i = 1'b0;
        sb_q.delete();
        repeat (3) @(negedge clock);
        chk("midreset_no_tx", 64'(tx_start_o), 64'(0));

        base = rx_cnt;
        push_dump(32'd1, 7'd1);
        send_cmd(8'h73);
        wait_dump(5000, "restep");
        chk("restep_bytes", 64'(rx_cnt - base), 64'(264));
        chk("restep_cycles", 64'(cycle_count_o), 64'(1));

        // Run from reset; HALT reaches fetch on the 10th enabled cycle.
        reset_i = 1'b1;
        @(negedge clock);
        reset_i = 1'b0;
        halt_arm = 1'b1;
        tx_delay = 50;
        base = rx_cnt;
        push_dump(32'd14, 7'd9);
        send_cmd(8'h63);
        chk("run_en", 64'(en_pipeline_o), 64'(1));
        chk("run_pc_en", 64'(pc_enable_o), 64'(1));
        n = 0;
        while (en_cnt != 9 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("halt_en", 64'(en_pipeline_o), 64'(1));
        chk("halt_pc_en", 64'(pc_enable_o), 64'(0));
        for (int d = 0; d < 4; d++) begin
            @(negedge clock);
            chk("drain_en", 64'(en_pipeline_o), 64'(1));
            chk("drain_pc_en", 64'(pc_enable_o), 64'(0));
        end
        @(negedge clock);
        chk("drain_end_en", 64'(en_pipeline_o), 64'(0));
        chk("drain_end_select", 64'(select_debug_o), 64'(1));

        n = 0;
        while (rx_cnt - base < 3 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        send_cmd(8'h63);
        wait_dump(20000, "halt_dump");
        chk("halt_bytes", 64'(rx_cnt - base), 64'(264));
        chk("halt_halted", 64'(halted_o), 64'(1));
        chk("halt_en_cycles", 64'(en_cnt), 64'(14));
        chk("halt_cycles", 64'(cycle_count_o), 64'(14));

        // HALTED ignores further commands.
        send_cmd(8'h73);
        repeat (20) @(negedge clock);
        chk("halted_ignore_en", 64'(en_cnt), 64'(14));
        chk("halted_ignore_tx", 64'(rx_cnt - base), 64'(264));
        chk("halted_stays", 64'(halted_o), 64'(1));
        chk("halted_busy", 64'(busy_o), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_run_controller.md
# pipeline_run_controller

Sequences the MIPS pipeline for the debug flow. After the program is loaded it accepts run and step commands and drives the pipeline and PC enables. It detects the HALT instruction at fetch and drains the pipeline. After every step and after halt, it walks the register file and data memory and streams a state dump to the UART transmitter one byte at a time.

## Interface
- NB_DATA, 32, datapath word width
- NB_REG, 5, register address width
- NB_ADDR, 7, data-memory word address width
- N_MEM_WORDS, 32, data-memory words dumped (1..2^NB_ADDR)
- DRAIN_CYCLES, 4, pipeline cycles after HALT fetch so HALT reaches WB
- HALT_OPCODE, 6'b111111, opcode field (instr[31:26]) meaning HALT

Ports:
- clock_i  in  1  single clock, rising edge
- reset_i  in  1  synchronous, active-high reset
- program_loaded_i  in  1  level; commands are ignored while low
- cmd_i  in  8  command byte: 0x63 'c' = run, 0x73 's' = step
- cmd_valid_i  in  1  one-cycle strobe qualifying cmd_i
- instruction_fetch_i  in  NB_DATA  instruction currently at fetch
- pc_i  in  7  current fetch PC
- data_registers_debug_i  in  NB_DATA  register file read data for addr_reg_debug_o
- data_mem_debug_i  in  NB_DATA  data memory read data for addr_mem_debug_o
- tx_done_i  in  1  one-cycle pulse, byte transmitted
- en_pipeline_o  out  1  advances all pipeline registers
- pc_enable_o  out  1  advances PC
- select_debug_o  out  1  steers register and memory read ports to debug addresses
- addr_reg_debug_o  out  NB_REG  register dump address
- addr_mem_debug_o  out  NB_ADDR  memory dump address
- tx_data_o  out  8  byte to send
- tx_start_o  out  1  one-cycle pulse that starts transmission of tx_data_o
- busy_o  out  1  high in any state except IDLE and HALTED
- halted_o  out  1  program has finished and its final dump has completed
- cycle_count_o  out  32  number of cycles with en_pipeline_o high

## Operation
- States: IDLE, RUN, STEP, DRAIN, DUMP_ADDR, DUMP_LATCH, DUMP_SEND, DUMP_WAIT, HALTED.
- IDLE: all enables are low. On cmd_valid_i with program_loaded_i=1, 'c' goes to RUN and 's' goes to STEP. Other bytes, and any byte while program_loaded_i=0, are dropped.
- RUN: en_pipeline_o=pc_enable_o=1. When instruction_fetch_i[31:26]==HALT_OPCODE, the same cycle drives pc_enable_o=0 and moves to DRAIN.
- STEP: a single cycle with en_pipeline_o=1, then DUMP. If HALT is at fetch, pc_enable_o=0 and the state goes to DRAIN instead.
- DRAIN: en_pipeline_o=1 and pc_enable_o=0 for exactly DRAIN_CYCLES cycles, then DUMP with the halt flag set.
- cmd_valid_i outside IDLE is ignored. Commands are not queued.
- The dump sends these words in order: cycle_count_o, {25'b0, pc_i}, registers 0..31, then memory words 0..N_MEM_WORDS-1.
  - Each word is sent MSB byte first.
  - Total bytes = 4*(34+N_MEM_WORDS); with defaults this is 264.
- select_debug_o=1 throughout the dump.
- Word sequencing:
  - DUMP_ADDR drives the address for the word.
  - DUMP_LATCH waits one settle cycle, then captures the selected word into a 32-bit shift register. The cycle count and PC are captured the same way.
  - For each byte, DUMP_SEND pulses tx_start_o and DUMP_WAIT holds until tx_done_i.
  - After the 4th byte the index advances. After the last word the state goes to HALTED if the halt flag is set, else to IDLE.
- cycle_count_o increments on every cycle with en_pipeline_o=1 and wraps modulo 2^32.
- HALTED: all enables are low and all commands are ignored. Only reset_i leaves this state.

## Timing
- Reset values:
  - state IDLE.
  - en_pipeline_o, pc_enable_o, select_debug_o, tx_start_o, busy_o, halted_o all 0.
  - addr_reg_debug_o, addr_mem_debug_o, tx_data_o all 0.
  - cycle_count_o 0.
- A command accepted at edge N drives its enables high in cycle N+1. A step is exactly one enabled cycle.
- tx_data_o is stable from the tx_start_o cycle until tx_done_i. tx_start_o is never high twice without an intervening tx_done_i.
- A tx_done_i in the same cycle as tx_start_o is ignored; only a later pulse counts.
- Per word: 2 cycles plus 4 × (1 + UART byte time).
- reset_i mid-dump or mid-drain aborts immediately. The next cycle shows all reset values; partial bytes are not completed.
- HALT fetched on the first RUN cycle still drains for the full DRAIN_CYCLES.

## Test plan
- Reset, then hold with commands asserted while program_loaded_i=0 -> all outputs stay at reset values and state stays IDLE.
- Load, send 's' with a non-HALT instruction -> en_pipeline_o high for 1 cycle, then 264 tx_start_o pulses.
  - First four bytes are 00 00 00 01; the bench register and memory models' values are reproduced MSB-first.
  - Ends in IDLE with halted_o=0.
- Send 'c' with HALT at fetch on the 10th run cycle -> pc_enable_o drops on that cycle and en_pipeline_o stays high 4 more cycles.
  - Dumped cycle count is 14 (0x0000000E).
  - halted_o=1 after the last byte; a later 's' is ignored.
- Bench delays tx_done_i 50 cycles per byte and pulses cmd_valid_i 'c' mid-dump -> tx_data_o is held stable, no extra tx_start_o occurs, and the command is dropped.
- Assert reset_i during the register-dump bytes -> the next cycle shows every output at its reset value; a fresh 's' restarts with a cycle count of 1.
- Unknown command 0x41 in IDLE -> no enable, no tx activity.
